alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It adds registered outputs, a start/busy/done handshake, and an iterative multiply/divide unit that writes architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO). It sits in the EX stage; the pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, default 32: data width. Must be a power of two, 8..64.
- `SHW`, localparam `$clog2(WIDTH)`: shift-amount width.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: operation request; accepted only when `busy`=0.
- `opcode  in  4`: operation select, sampled with `start`.
- `a  in  WIDTH`: operand A; also the shift amount source for shifts.
- `b  in  WIDTH`: operand B.
- `result  out  WIDTH`: registered result.
- `zero  out  1`: registered `result == 0`.
- `busy  out  1`: multiply/divide in progress.
- `done  out  1`: one-cycle pulse; `result` is valid while it is high.
- `hi  out  WIDTH`: HI register.
- `lo  out  WIDTH`: LO register.

## Operation
- Opcode map:
  - 0 AND, 1 OR, 2 ADD (wraps), 3 SUB (wraps), 4 SLT (signed, result 0/1), 5 NOR.
  - 6 SLL `b<<a[SHW-1:0]`, 7 SRL, 8 SRA (same shift amount).
  - 9 MULTU, 10 MULT, 11 DIVU, 12 DIV, 13 MFHI, 14 MFLO.
  - 15 reserved: `result`=0, `zero`=1.
- Single-cycle ops (0-8, 13-15):
  - On the accepting edge, `result`/`zero` are loaded and `done` is set.
  - `busy` stays 0; back-to-back issue every cycle is allowed.
- Multiply (9, 10):
  - Shift-add, one bit per cycle, on a 2·WIDTH product.
  - {HI,LO} = product; MULT is signed×signed.
- Divide (11, 12):
  - Restoring, one bit per cycle. LO = quotient, HI = remainder.
  - DIV truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = a (DIV and DIVU alike).
  - DIV of MIN / −1: LO = MIN, HI = 0.
- Signed mul/div: operate on magnitudes; sign fix-up happens in FIX.
- For mul/div, `result` = new LO and `zero` = (LO==0), both loaded with the HI/LO write.
- FSM:
  - IDLE → RUN on `start` with opcode 9-12. Operands are latched and the counter is set to WIDTH−1.
  - RUN → FIX when the counter reaches 0, after WIDTH iterations.
  - FIX → IDLE: HI/LO/`result`/`zero` are written and `done` is set.
- `start` while `busy`=1 is ignored: no queuing, no effect on state, HI/LO, `result` or `done`.
- MFHI/MFLO read HI/LO as of the issuing cycle. HI/LO change only in FIX.
- Reset values (including reset mid-operation): state IDLE, `busy`=0, `done`=0, `result`=0, `zero`=1, `hi`=`lo`=0. An aborted operation leaves no trace.

## Timing
- Single-cycle op accepted at edge k: `result`, `zero` and `done`=1 are visible after edge k; `done` drops after k+1 unless a new op is issued.
- Mul/div accepted at edge k:
  - `busy`=1 after edges k … k+WIDTH, i.e. WIDTH+1 cycles.
  - At edge k+WIDTH+1, `busy`→0 and `done`→1 in the same cycle.
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- The cycle after `done`, a new `start` is accepted.
- `rst` takes priority over `start` on the same edge.

## Structure
- Package `alu_pkg`:
  - Opcode localparams (`OP_AND` … `OP_MFLO`).
  - FSM state enum {IDLE, RUN, FIX}.
- Sub-module `alu_muldiv_core`: iterative mul/div datapath with counter and sign fix-up. It has handshake `go`/`fin` and outputs `hi_o`/`lo_o`.
- The top level holds the single-cycle ops, the output registers and HI/LO.

## Test plan
- ADD, a=101010101, b=11 → after 1 cycle: `result`=101010112, `zero`=0, `done`=1, `busy`=0. SUB, a=5, b=5 → `result`=0, `zero`=1.
- SRA, a=4, b=0x80000000 → 0xF8000000. SLT, a=0xFFFFFFFF, b=1 → 1. Opcode 15 → `result`=0, `zero`=1.
- MULT, a=0xFFFFFFFD (−3), b=7 → `busy` for 33 cycles, `done` at cycle 33, `hi`=0xFFFFFFFF, `lo`=`result`=0xFFFFFFEB. A following MFHI → 0xFFFFFFFF one cycle later.
- DIV, a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU, a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7. DIV, 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- During MULTU 0xFFFFFFFF×2, pulse ADD `start` at cycle 5 → ignored. Final `hi`=1, `lo`=0xFFFFFFFE, exactly one `done`.
- Assert `rst` at cycle 10 of MULTU → next cycle `busy`=0, `done`=0, `result`=0, `zero`=1, `hi`=`lo`=0. A subsequent ADD 2+3 → 5 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map and mul/div FSM states.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op inside {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV};
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// one bit per cycle, with sign fix-up applied in the FIX state.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             fin_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               b_zero_q, b_zero_d;

    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign a_neg     = is_signed & a_i[WIDTH-1];
    assign b_neg     = is_signed & b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_i) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulator: upper half is partial product / remainder, lower half is
    // multiplier / dividend being shifted out as quotient bits shift in.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        b_zero_d  = b_zero_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        if (state_q == IDLE && go_i) begin
            cnt_d     = SHW'(WIDTH - 1);
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            opnd_d    = b_mag;
            a_raw_d   = a_i;
            is_div_d  = (op_i == OP_DIVU) || (op_i == OP_DIV);
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            b_zero_d  = (b_i == '0);
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - SHW'(1);
            if (is_div_q) begin
                acc_d = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    // NOTE: datapath registers carry no reset; go always reloads them before use.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        acc_q     <= acc_d;
        opnd_q    <= opnd_d;
        a_raw_q   <= a_raw_d;
        is_div_q  <= is_div_d;
        neg_q     <= neg_d;
        rem_neg_q <= rem_neg_d;
        b_zero_q  <= b_zero_d;
    end

    always_comb begin
        busy_o   = (state_q != IDLE);
        fin_o    = (state_q == FIX);
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        prod_fix = neg_q ? -acc_q : acc_q;
        hi_o     = prod_fix[2*WIDTH-1:WIDTH];
        lo_o     = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                hi_o = a_raw_q;
                lo_o = '1;
            end else begin
                hi_o = rem_neg_q ? -rem : rem;
                lo_o = neg_q ? -quo : quo;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus an iterative
// mul/div unit writing HI/LO, with a start/busy/done handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_res, core_hi, core_lo;
    logic             core_busy, core_fin, accept, go;
    logic [SHW-1:0]   shamt;

    assign accept = start & ~core_busy;
    assign go     = accept & is_muldiv(opcode);
    assign shamt  = a[SHW-1:0];

    alu_muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .go_i   (go),
        .op_i   (opcode),
        .a_i    (a),
        .b_i    (b),
        .busy_o (core_busy),
        .fin_o  (core_fin),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // A mul/div finish and a single-cycle accept never coincide: FIX keeps busy high.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (core_fin) begin
            hi_d     = core_hi;
            lo_d     = core_lo;
            result_d = core_lo;
            zero_d   = (core_lo == '0);
            done_d   = 1'b1;
        end else if (accept && !is_muldiv(opcode)) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign done   = done_q;
    assign busy   = core_busy;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: randomized and directed ops against an
// arithmetic reference model of the opcode map and HI/LO behaviour.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   opcode;
    logic [W-1:0] a, b, result, hi, lo;
    logic         zero, busy, done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Reference model ----------------------------------------------------
    function automatic logic [W-1:0] ref_single(input logic [3:0] op, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        int unsigned sh;
        logic [W-1:0] fill;
        sh = x % W;
        fill = ~(ONES >> sh);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLT:  return (int'(x) < int'(y)) ? W'(1) : W'(0);
            OP_NOR:  return ~(x | y);
            OP_SLL:  return y << sh;
            OP_SRL:  return y >> sh;
            OP_SRA:  return y[W-1] ? ((y >> sh) | fill) : (y >> sh);
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return ZERO;
        endcase
    endfunction

    task automatic ref_muldiv(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                              output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint sp;
        logic [2*W-1:0] up;
        int sx, sy;
        sx = x;
        sy = y;
        rh = ZERO;
        rl = ZERO;
        case (op)
            OP_MULTU: begin
                up = (2*W)'(x) * (2*W)'(y);
                {rh, rl} = up;
            end
            OP_MULT: begin
                sp = longint'(sx) * longint'(sy);
                {rh, rl} = sp;
            end
            OP_DIVU: begin
                if (y == ZERO) begin rl = ONES; rh = x; end
                else begin rl = x / y; rh = x % y; end
            end
            default: begin
                if (y == ZERO) begin rl = ONES; rh = x; end
                else if (x == MIN && y == ONES) begin rl = MIN; rh = ZERO; end
                else begin rl = sx / sy; rh = sx % sy; end
            end
        endcase
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return ZERO;
            1:       return ONES;
            2:       return MIN;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Stimulus helpers (no comparisons) ----------------------------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, optionally pulsing an ADD start at edge inject_at.
    task automatic wait_done(input int inject_at, input logic [W-1:0] hold_val,
                             output int cycles, output bit early, output bit changed);
        cycles  = 0;
        early   = 1'b0;
        changed = 1'b0;
        for (int i = 1; i <= 2 * W; i++) begin
            if (i == inject_at) begin
                @(negedge clk);
                start  = 1'b1;
                opcode = OP_ADD;
                a      = W'(1);
                b      = W'(2);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                cycles = i;
                break;
            end
            if (!busy) early = 1'b1;
            if (result !== hold_val) changed = 1'b1;
        end
    endtask

    // Scenarios -----------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opcode = 4'd0; a = ZERO; b = ZERO;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result, zero, done, busy, hi, lo} !== {ZERO, 1'b1, 1'b0, 1'b0, ZERO, ZERO}) begin
            errors++;
            $display("FAIL reset_state: got result=%h zero=%b done=%b busy=%b hi=%h lo=%h, expected 0/1/0/0/0/0",
                     result, zero, done, busy, hi, lo);
        end
        @(negedge clk);
        start = 1'b1; opcode = OP_ADD; a = W'(2); b = W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({result, zero, done} !== {ZERO, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_priority: got result=%h zero=%b done=%b, expected 0/1/0", result, zero, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_cycle();
        logic [3:0] ops[$];
        logic [W-1:0] xs[$], ys[$];
        logic [3:0] pool[12] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLL,
                                 OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, 4'd15};
        logic [W-1:0] exp, prev;
        ops.push_back(OP_ADD);  xs.push_back(W'(101010101));  ys.push_back(W'(11));
        ops.push_back(OP_SUB);  xs.push_back(W'(5));          ys.push_back(W'(5));
        ops.push_back(OP_SRA);  xs.push_back(W'(4));          ys.push_back(MIN);
        ops.push_back(OP_SLT);  xs.push_back(ONES);           ys.push_back(W'(1));
        ops.push_back(4'd15);   xs.push_back(32'hDEADBEEF);   ys.push_back(32'h12345678);
        ops.push_back(OP_SLL);  xs.push_back(W'(31));         ys.push_back(W'(1));
        ops.push_back(OP_SRL);  xs.push_back(W'(32));         ys.push_back(32'hF0);
        ops.push_back(OP_AND);  xs.push_back(32'hFF00FF00);   ys.push_back(32'h0FF00FF0);
        ops.push_back(OP_NOR);  xs.push_back(ZERO);           ys.push_back(ZERO);
        for (int i = 0; i < 120; i++) begin
            ops.push_back(pool[$urandom_range(0, 11)]);
            xs.push_back(rnd_operand());
            ys.push_back(rnd_operand());
        end
        foreach (ops[i]) begin
            exp = ref_single(ops[i], xs[i], ys[i]);
            issue(ops[i], xs[i], ys[i]);
            checks++;
            if ({result, zero, done, busy} !== {exp, exp == ZERO, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL single op%0d a=%h b=%h: got result=%h zero=%b done=%b busy=%b, expected result=%h zero=%b done=1 busy=0",
                         ops[i], xs[i], ys[i], result, zero, done, busy, exp, exp == ZERO);
            end
            if (i >= 9 && $urandom_range(0, 3) == 0) begin
                prev = result;
                @(posedge clk);
                #1;
                checks++;
                if ({done, result} !== {1'b0, prev}) begin
                    errors++;
                    $display("FAIL done_drop: got done=%b result=%h, expected done=0 result=%h", done, result, prev);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0] ops[$];
        logic [W-1:0] xs[$], ys[$];
        logic [W-1:0] eh, el, prev, exp;
        logic [3:0] rop;
        int cycles;
        bit early, changed;
        ops.push_back(OP_MULT);  xs.push_back(32'hFFFFFFFD); ys.push_back(W'(7));
        ops.push_back(OP_DIV);   xs.push_back(32'hFFFFFFF9); ys.push_back(W'(2));
        ops.push_back(OP_DIVU);  xs.push_back(W'(7));        ys.push_back(ZERO);
        ops.push_back(OP_DIV);   xs.push_back(MIN);          ys.push_back(ONES);
        ops.push_back(OP_DIV);   xs.push_back(32'hFFFFFFF0); ys.push_back(ZERO);
        ops.push_back(OP_MULTU); xs.push_back(ONES);         ys.push_back(ONES);
        for (int i = 0; i < 14; i++) begin
            ops.push_back(4'(OP_MULTU + 4'($urandom_range(0, 3))));
            xs.push_back(rnd_operand());
            ys.push_back(rnd_operand());
        end
        foreach (ops[i]) begin
            ref_muldiv(ops[i], xs[i], ys[i], eh, el);
            prev = result;
            issue(ops[i], xs[i], ys[i]);
            checks++;
            if ({busy, done, result} !== {1'b1, 1'b0, prev}) begin
                errors++;
                $display("FAIL muldiv_accept op%0d: got busy=%b done=%b result=%h, expected busy=1 done=0 result=%h",
                         ops[i], busy, done, result, prev);
            end
            wait_done(0, prev, cycles, early, changed);
            checks++;
            if (cycles != W + 1 || early || changed) begin
                errors++;
                $display("FAIL muldiv_latency op%0d: got done after %0d edges (early_idle=%0b result_moved=%0b), expected %0d edges",
                         ops[i], cycles, early, changed, W + 1);
            end
            checks++;
            if ({hi, lo, result, zero, busy} !== {eh, el, el, el == ZERO, 1'b0}) begin
                errors++;
                $display("FAIL muldiv op%0d a=%h b=%h: got hi=%h lo=%h result=%h zero=%b busy=%b, expected hi=%h lo=%h zero=%b busy=0",
                         ops[i], xs[i], ys[i], hi, lo, result, zero, busy, eh, el, el == ZERO);
            end
            m_hi = eh;
            m_lo = el;
            rop = (i % 2 == 0) ? OP_MFHI : OP_MFLO;
            exp = ref_single(rop, rnd_operand(), rnd_operand());
            issue(rop, W'($urandom), W'($urandom));
            checks++;
            if ({result, done, busy} !== {exp, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL move_from op%0d: got result=%h done=%b busy=%b, expected result=%h done=1 busy=0",
                         rop, result, done, busy, exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] prev;
        int cycles;
        bit early, changed;
        prev = result;
        issue(OP_MULTU, ONES, W'(2));
        wait_done(5, prev, cycles, early, changed);
        checks++;
        if (cycles != W + 1 || early || changed) begin
            errors++;
            $display("FAIL ignore_start_timing: got done after %0d edges (early_idle=%0b result_moved=%0b), expected %0d edges",
                     cycles, early, changed, W + 1);
        end
        checks++;
        if ({hi, lo, result} !== {W'(1), 32'hFFFFFFFE, 32'hFFFFFFFE}) begin
            errors++;
            $display("FAIL ignore_start_value: got hi=%h lo=%h result=%h, expected hi=00000001 lo=fffffffe result=fffffffe",
                     hi, lo, result);
        end
        m_hi = W'(1);
        m_lo = 32'hFFFFFFFE;
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_done_pulse: got done=%b busy=%b, expected done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(OP_MULTU, W'($urandom) | W'(1), W'($urandom) | W'(1));
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, zero, hi, lo} !== {1'b0, 1'b0, ZERO, 1'b1, ZERO, ZERO}) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b result=%h zero=%b hi=%h lo=%h, expected 0/0/0/1/0/0",
                     busy, done, result, zero, hi, lo);
        end
        rst = 1'b0;
        m_hi = ZERO;
        m_lo = ZERO;
        issue(OP_ADD, W'(2), W'(3));
        checks++;
        if ({result, zero, done, busy} !== {W'(5), 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_after_reset: got result=%h zero=%b done=%b busy=%b, expected 00000005/0/1/0",
                     result, zero, done, busy);
        end
        repeat (W + 4) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi, lo, result} !== {1'b0, 1'b0, ZERO, ZERO, W'(5)}) begin
            errors++;
            $display("FAIL aborted_no_trace: got busy=%b done=%b hi=%h lo=%h result=%h, expected 0/0/0/0/00000005",
                     busy, done, hi, lo, result);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_start_ignored();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
